// File: rtl/i2s_dac_tx_pkg.sv
// Shared audio types and I2S defaults for the equalizer output path.
package i2s_dac_tx_pkg;

    localparam int SAMPLE_W     = 24;
    localparam int I2S_SLOT_W   = 32;
    localparam int I2S_BCLK_DIV = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // Position of a frame bit index inside its channel slot (0..slot_w-1).
    function automatic int slot_pos(input int bit_idx, input int slot_w);
        return (bit_idx >= slot_w) ? bit_idx - slot_w : bit_idx;
    endfunction

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample hand-over between the filter/gain mixer and the I2S transmitter.
//
// Handshake: the mixer drives left_in/right_in/sample_valid; the transmitter
// drives sample_ready. A pair transfers on a rising clk edge where
// sample_valid && sample_ready are both high. sample_ready is registered and
// only high while the holding buffer is empty; a valid pair presented while
// sample_ready is low is ignored (not queued), so the mixer must keep it
// stable until it sees ready.
interface i2s_dac_tx_if #(
    parameter int DATA_W = i2s_dac_tx_pkg::SAMPLE_W
);

    logic [DATA_W-1:0] left_in;
    logic [DATA_W-1:0] right_in;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output left_in,
        output right_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left_in,
        input  right_in,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/i2s_dac_tx_clk_gen.sv
// BCLK divider and frame bit counter for the I2S master transmitter.
// fe marks the clk cycle whose edge produces a BCLK falling edge; all serial
// outputs in the top update on that same edge.
module i2s_dac_tx_clk_gen import i2s_dac_tx_pkg::*; #(
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCLK_DIV = I2S_BCLK_DIV
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          bclk,
    output logic                          fe,
    output logic                          frame_start,
    output logic                          lrck_next,
    output logic [$clog2(2*SLOT_W)-1:0]   bit_cnt
);

    localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2*SLOT_W);

    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [BIT_W-1:0] bit_next;
    logic             last_bit;

    // Divider wrap, falling-edge strobe and next bit position.
    always_comb begin
        fe          = (clk_cnt == CNT_W'(BCLK_DIV-1));
        cnt_next    = fe ? '0 : clk_cnt + CNT_W'(1);
        last_bit    = (bit_cnt == BIT_W'(2*SLOT_W-1));
        frame_start = fe && last_bit;
        bit_next    = last_bit ? '0 : bit_cnt + BIT_W'(1);
        lrck_next   = (bit_next >= BIT_W'(SLOT_W));
    end

    // Divider count, registered BCLK level and bit counter advance on fe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            clk_cnt <= cnt_next;
            bclk    <= (cnt_next >= CNT_W'(BCLK_DIV/2));
            if (fe) begin
                bit_cnt <= bit_next;
            end
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter towards the audio DAC. A single holding buffer takes
// the next stereo pair from the mixer while the current frame shifts out; at
// each frame boundary the buffer moves into the shift registers (or zeros are
// sent and underrun pulses if the mixer did not deliver in time).
module i2s_dac_tx import i2s_dac_tx_pkg::*; #(
    parameter int DATA_W   = SAMPLE_W,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCLK_DIV = I2S_BCLK_DIV
) (
    input  logic         clk,
    input  logic         reset_n,
    i2s_dac_tx_if.slave  smp,
    output logic         underrun,
    output logic         i2s_bclk,
    output logic         i2s_lrck,
    output logic         i2s_sdata
);

    localparam int BIT_W = $clog2(2*SLOT_W);

    logic              fe;
    logic              frame_start;
    logic              lrck_next;
    logic [BIT_W-1:0]  bit_cnt;

    logic              buf_full;
    logic              buf_full_next;
    logic              ready_q;
    logic [DATA_W-1:0] buf_l;
    logic [DATA_W-1:0] buf_r;
    logic [DATA_W-1:0] shift_l;
    logic [DATA_W-1:0] shift_r;

    logic              accept;
    logic [BIT_W-1:0]  bit_nxt;
    int                slot_b;
    logic              data_bit;

    i2s_dac_tx_clk_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .bclk        (i2s_bclk),
        .fe          (fe),
        .frame_start (frame_start),
        .lrck_next   (lrck_next),
        .bit_cnt     (bit_cnt)
    );

    assign smp.sample_ready = ready_q;

    // Handshake and buffer occupancy; a frame load frees the buffer, an
    // accept fills it (accept only happens when it was already empty, so the
    // load in the same cycle saw an empty buffer and sent zeros).
    always_comb begin
        accept        = smp.sample_valid && ready_q;
        buf_full_next = buf_full;
        if (frame_start) begin
            buf_full_next = 1'b0;
        end
        if (accept) begin
            buf_full_next = 1'b1;
        end
    end

    // Slot position of the bit that the coming falling edge presents.
    always_comb begin
        bit_nxt  = frame_start ? '0 : bit_cnt + BIT_W'(1);
        slot_b   = slot_pos(int'(bit_nxt), SLOT_W);
        data_bit = (slot_b >= 1) && (slot_b <= DATA_W);
    end

    // Holding buffer and registered ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full <= 1'b0;
            ready_q  <= 1'b1;
            buf_l    <= '0;
            buf_r    <= '0;
        end else begin
            if (accept) begin
                buf_l <= smp.left_in;
                buf_r <= smp.right_in;
            end
            buf_full <= buf_full_next;
            ready_q  <= !buf_full_next;
        end
    end

    // Frame load, MSB-first shifting with one-BCLK delay after LRCK, and the
    // underrun pulse when a frame starts from an empty buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_l   <= '0;
            shift_r   <= '0;
            i2s_sdata <= 1'b0;
            i2s_lrck  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= frame_start && !buf_full;
            if (fe) begin
                i2s_lrck <= lrck_next;
                if (frame_start) begin
                    shift_l   <= buf_full ? buf_l : '0;
                    shift_r   <= buf_full ? buf_r : '0;
                    i2s_sdata <= 1'b0;
                end else if (data_bit && !lrck_next) begin
                    i2s_sdata <= shift_l[DATA_W-1];
                    shift_l   <= shift_l << 1;
                end else if (data_bit) begin
                    i2s_sdata <= shift_r[DATA_W-1];
                    shift_r   <= shift_r << 1;
                end else begin
                    i2s_sdata <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for the I2S DAC transmitter. The reference model works at frame
// level: every 256 clks after reset a frame boundary occurs; the frame then
// carries the buffered pair, or silence plus an underrun pulse. Each frame's
// expected 64-bit serial image is queued and compared against the bits
// recovered from the I2S pins by an independent deserialiser.
module tb_i2s_dac_tx;
    import i2s_dac_tx_pkg::*;

    localparam int FRAME_CLKS = 256;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic underrun;
    logic i2s_bclk;
    logic i2s_lrck;
    logic i2s_sdata;

    i2s_dac_tx_if #(.DATA_W(SAMPLE_W)) smp ();

    i2s_dac_tx #(
        .DATA_W   (SAMPLE_W),
        .SLOT_W   (32),
        .BCLK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .smp       (smp),
        .underrun  (underrun),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrck  (i2s_lrck),
        .i2s_sdata (i2s_sdata)
    );

    // Clock.
    always #5 clk = ~clk;

    // Counters and comparison helper.
    int n_cmp    = 0;
    int n_bad    = 0;
    int n_frames = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level buffer behaviour.
    logic [63:0] exp_q[$];
    stereo_t     m_buf;
    bit          m_full;
    bit          m_ready;
    bit          m_underrun;
    bit          m_acc;
    int          e;

    function automatic logic [63:0] frame_of(input stereo_t p);
        return {1'b0, p.l, 7'b0, 1'b0, p.r, 7'b0};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e          = 0;
            m_full     = 1'b0;
            m_ready    = 1'b1;
            m_underrun = 1'b0;
            exp_q.delete();
            exp_q.push_back(64'h0);   // frame running out of reset is silent
        end else begin
            m_acc      = (smp.sample_valid === 1'b1) && m_ready;
            e          = e + 1;
            m_underrun = 1'b0;
            if (e % FRAME_CLKS == 0) begin
                if (m_full) begin
                    exp_q.push_back(frame_of(m_buf));
                    m_full = 1'b0;
                end else begin
                    exp_q.push_back(64'h0);
                    m_underrun = 1'b1;
                end
            end
            if (m_acc) begin
                m_buf.l = smp.left_in;
                m_buf.r = smp.right_in;
                m_full  = 1'b1;
            end
            m_ready = !m_full;
        end
    end

    // Per-cycle checks of the handshake and underrun pulse.
    always @(negedge clk) begin
        if (checking) begin
            check("sample_ready", 64'(smp.sample_ready), 64'(m_ready));
            check("underrun", 64'(underrun), 64'(m_underrun));
        end
    end

    // Deserialiser: sample on BCLK rising edges, slot boundaries from LRCK.
    logic [31:0] mon_slot;
    logic [31:0] mon_left;
    logic        mon_lr;
    int          mon_cnt;
    logic [63:0] exp_frame;

    initial begin
        mon_slot = '0;
        mon_left = '0;
        mon_lr   = 1'b0;
        mon_cnt  = 0;
        forever begin
            @(posedge i2s_bclk or negedge reset_n);
            if (!reset_n) begin
                mon_slot = '0;
                mon_left = '0;
                mon_lr   = 1'b0;
                mon_cnt  = 0;
            end else begin
                #1;
                if (i2s_lrck !== mon_lr) begin
                    check("slot_len", 64'(mon_cnt), 64'd32);
                    if (mon_lr == 1'b1) begin
                        check("exp_avail", 64'(exp_q.size() > 0), 64'd1);
                        if (exp_q.size() > 0) begin
                            exp_frame = exp_q.pop_front();
                            n_frames++;
                            check("frame", {mon_left, mon_slot}, exp_frame);
                        end
                    end else begin
                        mon_left = mon_slot;
                    end
                    mon_lr  = i2s_lrck;
                    mon_cnt = 0;
                end
                mon_slot = {mon_slot[30:0], i2s_sdata};
                mon_cnt++;
            end
        end
    end

    // Driver tasks.
    task automatic send(input logic [23:0] l, input logic [23:0] r);
        smp.left_in      = l;
        smp.right_in     = r;
        smp.sample_valid = 1'b1;
        for (int i = 0; i < 1000 && smp.sample_ready !== 1'b1; i++)
            @(negedge clk);
        check("send_ready_seen", 64'(smp.sample_ready), 64'd1);
        @(negedge clk);
        smp.sample_valid = 1'b0;
    endtask

    task automatic align_to(input int phase);
        for (int i = 0; i < FRAME_CLKS + 2 && (e % FRAME_CLKS) != phase; i++)
            @(negedge clk);
        check("align", 64'(e % FRAME_CLKS), 64'(phase));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"},     64'(i2s_bclk),         64'd0);
        check({tag, "_lrck"},     64'(i2s_lrck),         64'd0);
        check({tag, "_sdata"},    64'(i2s_sdata),        64'd0);
        check({tag, "_underrun"}, 64'(underrun),         64'd0);
        check({tag, "_ready"},    64'(smp.sample_ready), 64'd1);
    endtask

    // Stimulus sequence.
    logic [23:0] l;
    logic [23:0] r;
    bit          bclk_pat [4];

    initial begin
        bclk_pat = '{1'b0, 1'b1, 1'b1, 1'b0};
        smp.left_in      = '0;
        smp.right_in     = '0;
        smp.sample_valid = 1'b0;

        // 1: reset for 5 clks, then the divider start-up pattern.
        #1 reset_n = 1'b0;
        checking = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bclk_start", 64'(i2s_bclk), 64'(bclk_pat[k]));
        end

        // 2: single known pair.
        send(24'h800001, 24'h7FFFFE);

        // 3: back-to-back incrementing pairs from a random base.
        l = 24'($urandom());
        r = 24'($urandom());
        for (int i = 0; i < 6; i++)
            send(l + 24'(i), r - 24'(i));

        // 4: starve the transmitter for several frames.
        repeat (4 * FRAME_CLKS) @(negedge clk);

        // 5: valid raised exactly on the frame-load clk with an empty buffer.
        align_to(FRAME_CLKS - 1);
        send(24'($urandom()), 24'($urandom()));
        check("load_clk_underrun", 64'(underrun), 64'd1);
        check("load_clk_ready", 64'(smp.sample_ready), 64'd0);
        repeat (2 * FRAME_CLKS) @(negedge clk);

        // 6: reset in the middle of a loaded frame.
        l = 24'($urandom()) | 24'h004000;
        send(l, 24'($urandom()));
        align_to(0);
        align_to(41);
        check("pre_reset_sdata", 64'(i2s_sdata), 64'(l[14]));
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (FRAME_CLKS / 2) @(negedge clk);
        send(24'($urandom()), 24'($urandom()));
        repeat (3 * FRAME_CLKS) @(negedge clk);

        check("frames_seen", 64'(n_frames >= 12), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
